gpu_bus_writer: RTL
===================

GPU_BUS_WRITER -- requirements
Module: gpu_bus_writer

Interface
REQ-001 Parameter CLK_DIV, default 4: CLK cycles per half period of GPU_CLK_CPU; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 16: command FIFO entries; power of two.
REQ-003 Parameter HOLDOFF_CLEAR, default 4802: idle CPU cycles after a clear strobe (80*60 clear + 2).
REQ-004 Port CLK, input, 1: sole clock; every register in the block is clocked on its rising edge.
REQ-005 Port RESET_N, input, 1: asynchronous, active-low reset.
REQ-006 Port IN_DATA, input, 7: character code.
REQ-007 Port IN_CMD, input, 1: 0 = character write, 1 = screen clear; IN_DATA is ignored when IN_CMD = 1.
REQ-008 Port IN_VALID, input, 1: the upstream entry is valid.
REQ-009 Port IN_READY, output, 1: the FIFO is not full.
REQ-010 Port GPU_CLK_CPU, output, 1: divided bus clock; the GPU samples the bus on its falling edge.
REQ-011 Port GPU_CE, output, 1: chip enable, active-low.
REQ-012 Port GPU_RW, output, 1: 0 = write; the block never issues reads.
REQ-013 Port GPU_ADDR, output, 2: register select.
REQ-014 Port GPU_DATA, output, 7: write data.
REQ-015 Port BUSY, output, 1: high when the FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-016 A divider SHALL toggle GPU_CLK_CPU every CLK_DIV CLK cycles.
- RISE tick: the CLK cycle where GPU_CLK_CPU goes 0->1.
- FALL tick: the CLK cycle where GPU_CLK_CPU goes 1->0.
REQ-017 GPU_CE, GPU_RW, GPU_ADDR and GPU_DATA SHALL change only on RISE ticks.
REQ-018 A FIFO push SHALL occur on each CLK cycle with IN_VALID and IN_READY both high.
REQ-019 A push and a pop in the same cycle SHALL both take effect; the occupancy count is unchanged.
REQ-020 FSM states:
- IDLE -> LOAD when the FIFO is non-empty (pop into the holding register).
- LOAD -> STROBE at the next RISE tick.
- STROBE -> HOLD at the following RISE tick.
- HOLD -> IDLE when the holdoff counter reaches 0, evaluated on RISE ticks.
REQ-021 In STROBE the block SHALL drive GPU_CE=0 and GPU_RW=0 for exactly one GPU_CLK_CPU period, so exactly one GPU falling edge sees CE low.
REQ-022 In STROBE with a character entry, the block SHALL drive GPU_ADDR=ADDR_CHAR and GPU_DATA=IN_DATA.
REQ-023 In STROBE with a clear entry, the block SHALL drive GPU_ADDR=ADDR_CLEAR and GPU_DATA=0.
REQ-024 In all states other than STROBE, the block SHALL drive GPU_CE=1 and GPU_RW=1, with GPU_ADDR and GPU_DATA held at their last values.
REQ-025 The HOLD duration SHALL be 1 CPU cycle after a character write and HOLDOFF_CLEAR CPU cycles after a clear.
REQ-026 Back-to-back character writes SHALL therefore produce CE low falling edges spaced 3 CPU periods apart.
REQ-027 The holdoff counter SHALL be 13 bits wide and SHALL saturate at 0.
REQ-028 Entries SHALL be issued in FIFO order, never dropped or duplicated.
REQ-029 When the FIFO is full, IN_READY SHALL be 0 and IN_VALID SHALL be ignored.

Reset
REQ-030 While RESET_N is low, outputs SHALL be: GPU_CLK_CPU=0, GPU_CE=1, GPU_RW=1, GPU_ADDR=0, GPU_DATA=0, IN_READY=0, BUSY=1.
REQ-031 While RESET_N is low, the FIFO SHALL be emptied and the divider SHALL be cleared.
REQ-032 After RESET_N deasserts, the FSM SHALL enter HOLD with a HOLDOFF_CLEAR count, because the GPU may be mid-clear.
REQ-033 IN_READY SHALL rise on the first CLK cycle after RESET_N deasserts.
REQ-034 Reset asserted during STROBE SHALL raise GPU_CE immediately (asynchronously).

Configuration
REQ-035 With GPU_WRITER_CRLF_EN defined, a popped character 0x0A SHALL be issued as two strobes, 0x0D then 0x0A, each followed by a character holdoff.
REQ-036 With GPU_WRITER_CRLF_EN defined, the FSM SHALL add state EXPAND between HOLD and the second LOAD.
REQ-037 Without GPU_WRITER_CRLF_EN, 0x0A SHALL be issued as one strobe and state EXPAND SHALL not exist.

Structure
REQ-038 Package gpu_pkg SHALL hold:
- ADDR_CHAR=2'b00, ADDR_CLEAR=2'b01
- FB_COLS=80, FB_ROWS=60
- CHAR_LF=7'h0A, CHAR_CR=7'h0D
- the FSM state enumeration
REQ-039 The FIFO SHALL be sub-module gpu_cmd_fifo (synchronous, single clock, with count output).
REQ-040 The divider, FSM and holdoff counter SHALL reside in gpu_bus_writer.

Verification (CLK_DIV=2, HOLDOFF_CLEAR=10 unless stated)
REQ-041 Push 'A' (0x41) after reset holdoff -> exactly one GPU falling edge samples CE=0, RW=0, ADDR=00, DATA=0x41; BUSY falls 1 CPU cycle later.
REQ-042 Push 'H','I' back-to-back -> CE-low falling edges spaced 3 CPU periods apart, data 0x48 then 0x49.
REQ-043 Push a clear then 'X' -> ADDR=01 strobe, then no CE low for 10 CPU periods, then 0x58.
REQ-044 Push 17 entries with the GPU stalled by a clear, FIFO_DEPTH=16 -> IN_READY low after 16 accepted entries; all 16 issued in order.
REQ-045 Assert RESET_N low mid-STROBE -> CE high within the same CLK cycle; no strobe for 10 CPU periods after release.
REQ-046 GPU_WRITER_CRLF_EN defined, push 0x0A -> strobes 0x0D then 0x0A; undefined -> single strobe 0x0A.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU bus writer.
// Optional CR/LF expansion state is enabled by GPU_WRITER_CRLF_EN.
package gpu_pkg;

  localparam logic [1:0] ADDR_CHAR  = 2'b00;
  localparam logic [1:0] ADDR_CLEAR = 2'b01;

  localparam int FB_COLS = 80;
  localparam int FB_ROWS = 60;

  localparam logic [6:0] CHAR_LF = 7'h0A;
  localparam logic [6:0] CHAR_CR = 7'h0D;

  localparam int HOLD_W = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STROBE,
`ifdef GPU_WRITER_CRLF_EN
    S_HOLD,
    S_EXPAND
`else
    S_HOLD
`endif
  } wr_state_t;

  typedef struct packed {
    logic       clr;
    logic [6:0] ch;
  } gpu_cmd_t;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Single-clock show-ahead command FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module gpu_cmd_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     push,
  input  logic                     pop,
  input  gpu_cmd_t                 wr_data,
  output gpu_cmd_t                 rd_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  gpu_cmd_t         mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_bus_writer.sv
// Drives the GPU CPU-style write bus from a command FIFO.
// Define GPU_WRITER_CRLF_EN to expand LF into a CR,LF pair.
module gpu_bus_writer
  import gpu_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int FIFO_DEPTH    = 16,
  parameter int HOLDOFF_CLEAR = FB_COLS * FB_ROWS + 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [6:0] IN_DATA,
  input  logic       IN_CMD,
  input  logic       IN_VALID,
  output logic       IN_READY,
  output logic       GPU_CLK_CPU,
  output logic       GPU_CE,
  output logic       GPU_RW,
  output logic [1:0] GPU_ADDR,
  output logic [6:0] GPU_DATA,
  output logic       BUSY
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  localparam logic [HOLD_W-1:0] HOLD_CLR =
    HOLD_W'(HOLDOFF_CLEAR - 1);

  logic [7:0]        div_cnt;
  logic              gclk;
  logic              rise;

  wr_state_t         state;
  wr_state_t         state_d;
  logic [HOLD_W-1:0] hcnt;
  logic [HOLD_W-1:0] hcnt_d;
  gpu_cmd_t          ent;
  gpu_cmd_t          ent_d;
  logic              ce;
  logic              ce_d;
  logic              rw;
  logic              rw_d;
  logic [1:0]        addr;
  logic [1:0]        addr_d;
  logic [6:0]        data;
  logic [6:0]        data_d;
  logic              rdy_en;
`ifdef GPU_WRITER_CRLF_EN
  logic              lf_pend;
  logic              lf_pend_d;
`endif

  gpu_cmd_t          fifo_wr;
  gpu_cmd_t          fifo_rd;
  logic              fifo_full;
  logic [CW-1:0]     fifo_cnt;
  logic              push;
  logic              pop;

  assign IN_READY = rdy_en && !fifo_full;
  assign push     = IN_VALID && IN_READY;
  assign fifo_wr  = '{clr: IN_CMD,
                      ch:  IN_CMD ? 7'h00 : IN_DATA};

  gpu_cmd_fifo #(
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (push),
    .pop     (pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .count   (fifo_cnt)
  );

  // rise marks the CLK cycle whose edge takes GPU_CLK_CPU 0->1
  assign rise = (div_cnt == DIV_LAST) && !gclk;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt <= '0;
      gclk    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      gclk    <= ~gclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d   = state;
    hcnt_d    = hcnt;
    ent_d     = ent;
    ce_d      = ce;
    rw_d      = rw;
    addr_d    = addr;
    data_d    = data;
    pop       = 1'b0;
`ifdef GPU_WRITER_CRLF_EN
    lf_pend_d = lf_pend;
`endif
    case (state)
      S_IDLE: begin
        if (fifo_cnt != '0) begin
          pop     = 1'b1;
          ent_d   = fifo_rd;
          state_d = S_LOAD;
`ifdef GPU_WRITER_CRLF_EN
          if (!fifo_rd.clr && fifo_rd.ch == CHAR_LF) begin
            ent_d.ch  = CHAR_CR;
            lf_pend_d = 1'b1;
          end
`endif
        end
      end
      S_LOAD: begin
        if (rise) begin
          state_d = S_STROBE;
          ce_d    = 1'b0;
          rw_d    = 1'b0;
          addr_d  = ent.clr ? ADDR_CLEAR : ADDR_CHAR;
          data_d  = ent.clr ? 7'h00 : ent.ch;
        end
      end
      S_STROBE: begin
        if (rise) begin
          state_d = S_HOLD;
          ce_d    = 1'b1;
          rw_d    = 1'b1;
          hcnt_d  = ent.clr ? HOLD_CLR : '0;
        end
      end
      S_HOLD: begin
        if (rise) begin
          if (hcnt == '0) begin
`ifdef GPU_WRITER_CRLF_EN
            state_d = lf_pend ? S_EXPAND : S_IDLE;
`else
            state_d = S_IDLE;
`endif
          end else begin
            hcnt_d = hcnt - 1'b1;
          end
        end
      end
`ifdef GPU_WRITER_CRLF_EN
      S_EXPAND: begin
        ent_d.ch  = CHAR_LF;
        lf_pend_d = 1'b0;
        state_d   = S_LOAD;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset lands in HOLD: the GPU may still be mid-clear
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_HOLD;
      hcnt    <= HOLD_CLR;
      ent     <= '0;
      ce      <= 1'b1;
      rw      <= 1'b1;
      addr    <= '0;
      data    <= '0;
      rdy_en  <= 1'b0;
`ifdef GPU_WRITER_CRLF_EN
      lf_pend <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      hcnt    <= hcnt_d;
      ent     <= ent_d;
      ce      <= ce_d;
      rw      <= rw_d;
      addr    <= addr_d;
      data    <= data_d;
      rdy_en  <= 1'b1;
`ifdef GPU_WRITER_CRLF_EN
      lf_pend <= lf_pend_d;
`endif
    end
  end

  assign GPU_CLK_CPU = gclk;
  assign GPU_CE      = ce;
  assign GPU_RW      = rw;
  assign GPU_ADDR    = addr;
  assign GPU_DATA    = data;
  assign BUSY        = (fifo_cnt != '0) || (state != S_IDLE);

endmodule
